// File: rtl/blink_clock_divider.sv
// Turn-signal / hazard light sequencer with a programmable divider that produces a
// registered slow clock and an internal single-cycle step enable (one clock domain).
module blink_clock_divider #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] divide_by,
    input  logic             hazards,
    input  logic             turnChange,
    output logic             clock_out,
    output logic [2:0]       leftLEDs,
    output logic [2:0]       rightLEDs,
    output logic [7:0]       hex
);

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_HAZ   = 2'd3
    } mode_t;

    function automatic logic [2:0] lamp_advance(input logic [2:0] lamps);
        case (lamps)
            3'b000:  lamp_advance = 3'b001;
            3'b001:  lamp_advance = 3'b011;
            3'b011:  lamp_advance = 3'b111;
            default: lamp_advance = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] hex_glyph(input mode_t m);
        case (m)
            MODE_LEFT:  hex_glyph = 8'hC7;
            MODE_RIGHT: hex_glyph = 8'hAF;
            MODE_HAZ:   hex_glyph = 8'h89;
            default:    hex_glyph = 8'hFF;
        endcase
    endfunction

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] limit;
    logic             wrap;
    logic             step;

    // >= rather than == so a limit lowered below the running count wraps at once
    always_comb begin
        limit = (divide_by == '0) ? CNT_W'(1) : divide_by;
        wrap  = (counter >= limit - CNT_W'(1));
        step  = wrap & ~clock_out;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter   <= '0;
            clock_out <= 1'b0;
        end else if (wrap) begin
            counter   <= '0;
            clock_out <= ~clock_out;
        end else begin
            counter   <= counter + CNT_W'(1);
        end
    end

    mode_t      mode;
    mode_t      mode_in;
    mode_t      mode_next;
    logic       mode_change;
    logic [2:0] left_next;
    logic [2:0] right_next;
    logic [7:0] hex_next;

    // MODE_NONE after reset adopts the input mode on the first edge without a clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode      <= MODE_NONE;
            leftLEDs  <= 3'b000;
            rightLEDs <= 3'b000;
            hex       <= 8'hFF;
        end else begin
            mode      <= mode_next;
            leftLEDs  <= left_next;
            rightLEDs <= right_next;
            hex       <= hex_next;
        end
    end

    always_comb begin
        mode_in = hazards ? MODE_HAZ : (turnChange ? MODE_LEFT : MODE_RIGHT);
        mode_change = (mode != MODE_NONE) && (mode_in != mode);
        mode_next = mode_in;
    end

    always_comb begin
        left_next  = leftLEDs;
        right_next = rightLEDs;
        hex_next   = hex_glyph(mode_next);
        if (mode_change) begin
            left_next  = 3'b000;
            right_next = 3'b000;
        end else if (step) begin
            case (mode_in)
                MODE_LEFT: begin
                    left_next  = lamp_advance(leftLEDs);
                    right_next = 3'b000;
                end
                MODE_RIGHT: begin
                    left_next  = 3'b000;
                    right_next = lamp_advance(rightLEDs);
                end
                default: begin
                    left_next  = (leftLEDs == 3'b000) ? 3'b111 : 3'b000;
                    right_next = left_next;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_clock_divider.sv
// Directed bench for blink_clock_divider: a table of per-edge vectors plus
// hand-written reset sequences.
module tb_blink_clock_divider;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] divide_by;
    logic        hazards;
    logic        turnChange;
    logic        clock_out;
    logic [2:0]  leftLEDs;
    logic [2:0]  rightLEDs;
    logic [7:0]  hex;

    blink_clock_divider #(.CNT_W(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .divide_by  (divide_by),
        .hazards    (hazards),
        .turnChange (turnChange),
        .clock_out  (clock_out),
        .leftLEDs   (leftLEDs),
        .rightLEDs  (rightLEDs),
        .hex        (hex)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        hz;
        logic        tc;
        logic [31:0] div;
        logic        clk;
        logic [2:0]  left;
        logic [2:0]  right;
        logic [7:0]  hx;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic add(input logic hz, input logic tc, input logic [31:0] div,
                       input logic clk, input logic [2:0] l, input logic [2:0] r,
                       input logic [7:0] hx, input int n = 1);
        vec_t v;
        v.hz = hz; v.tc = tc; v.div = div; v.clk = clk;
        v.left = l; v.right = r; v.hx = hx;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic clk, input logic [2:0] l,
                         input logic [2:0] r, input logic [7:0] hx);
        total++;
        if (clock_out === clk && leftLEDs === l && rightLEDs === r && hex === hx)
            passed++;
        else
            $display("FAIL %s: got clk=%b left=%b right=%b hex=%h, want clk=%b left=%b right=%b hex=%h",
                     name, clock_out, leftLEDs, rightLEDs, hex, clk, l, r, hx);
    endtask

    initial begin
        // left sequence, divide_by = 1
        add(0,1,1, 1,3'b001,3'b000,8'hC7);
        add(0,1,1, 0,3'b001,3'b000,8'hC7);
        add(0,1,1, 1,3'b011,3'b000,8'hC7);
        add(0,1,1, 0,3'b011,3'b000,8'hC7);
        add(0,1,1, 1,3'b111,3'b000,8'hC7);
        add(0,1,1, 0,3'b111,3'b000,8'hC7);
        add(0,1,1, 1,3'b000,3'b000,8'hC7);
        add(0,1,1, 0,3'b000,3'b000,8'hC7);
        add(0,1,1, 1,3'b001,3'b000,8'hC7);
        add(0,1,1, 0,3'b001,3'b000,8'hC7);
        add(0,1,1, 1,3'b011,3'b000,8'hC7);
        // direction change while left = 011
        add(0,0,1, 0,3'b000,3'b000,8'hAF);
        add(0,0,1, 1,3'b000,3'b001,8'hAF);
        add(0,0,1, 0,3'b000,3'b001,8'hAF);
        add(0,0,1, 1,3'b000,3'b011,8'hAF);
        add(0,0,1, 0,3'b000,3'b011,8'hAF);
        add(0,0,1, 1,3'b000,3'b111,8'hAF);
        // hazards, turnChange ignored
        add(1,0,1, 0,3'b000,3'b000,8'h89);
        add(1,0,1, 1,3'b111,3'b111,8'h89);
        add(1,1,1, 0,3'b111,3'b111,8'h89);
        add(1,1,1, 1,3'b000,3'b000,8'h89);
        add(1,0,1, 0,3'b000,3'b000,8'h89);
        add(1,0,1, 1,3'b111,3'b111,8'h89);
        add(1,0,1, 0,3'b111,3'b111,8'h89);
        // mode change on a step edge: step is dropped
        add(0,1,1, 1,3'b000,3'b000,8'hC7);
        add(0,1,1, 0,3'b000,3'b000,8'hC7);
        add(0,1,1, 1,3'b001,3'b000,8'hC7);
        // divide_by = 0 acts as 1
        add(0,1,0, 0,3'b001,3'b000,8'hC7);
        add(0,1,0, 1,3'b011,3'b000,8'hC7);
        add(0,1,0, 0,3'b011,3'b000,8'hC7);
        // divide_by = 4: period 8
        add(0,1,4, 0,3'b011,3'b000,8'hC7, 3);
        add(0,1,4, 1,3'b111,3'b000,8'hC7, 4);
        add(0,1,4, 0,3'b111,3'b000,8'hC7, 4);
        add(0,1,4, 1,3'b000,3'b000,8'hC7, 4);
        add(0,1,4, 0,3'b000,3'b000,8'hC7, 4);
        add(0,1,4, 1,3'b001,3'b000,8'hC7, 4);
        // limit lowered below running count (3) -> immediate wrap
        add(0,1,2, 0,3'b001,3'b000,8'hC7, 2);
        add(0,1,2, 1,3'b011,3'b000,8'hC7);
        add(0,1,1, 0,3'b011,3'b000,8'hC7);
        add(0,1,1, 1,3'b111,3'b000,8'hC7);

        reset_n = 1'b0; divide_by = 32'd1; hazards = 1'b0; turnChange = 1'b1;
        #12;
        check("reset_state", 1'b0, 3'b000, 3'b000, 8'hFF);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            hazards    = vecs[i].hz;
            turnChange = vecs[i].tc;
            divide_by  = vecs[i].div;
            @(posedge clock);
            #1;
            check($sformatf("edge%0d", i + 1), vecs[i].clk, vecs[i].left, vecs[i].right, vecs[i].hx);
            @(negedge clock);
        end

        // async reset between edges while lamps = 111
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 3'b000, 3'b000, 8'hFF);
        @(posedge clock);
        #1;
        check("held_in_reset", 1'b0, 3'b000, 3'b000, 8'hFF);

        // release with hazards: first edge adopts HAZ and steps without a clear
        @(negedge clock);
        hazards = 1'b1; turnChange = 1'b0; divide_by = 32'd1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("haz_after_reset", 1'b1, 3'b111, 3'b111, 8'h89);
        @(posedge clock);
        #1;
        check("haz_hold", 1'b0, 3'b111, 3'b111, 8'h89);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
